// File: rtl/parking_pkg.sv
// Shared types and defaults for the parking gate arbiter: FSM states,
// default lane counts and timings, and the lane-index width helper.
package parking_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EVAL   = 2'd1,
        COMMIT = 2'd2,
        SETTLE = 2'd3
    } state_t;

    localparam int DEF_NUM_ENTRY     = 2;
    localparam int DEF_NUM_EXIT      = 2;
    localparam int DEF_OPEN_CYCLES   = 16;
    localparam int DEF_SETTLE_CYCLES = 2;

    function automatic int lane_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/parking_rr_arbiter.sv
// Rotating-priority picker: the first requesting lane after last_lane
// (with wrap) wins; reports one-hot grant, its index and whether any won.
module parking_rr_arbiter #(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] last_lane,
    output logic [N-1:0] grant,
    output logic [W-1:0] idx,
    output logic         any
);

    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        for (int k = 1; k <= N; k++) begin
            if (!any && req[(int'(last_lane) + k) % N]) begin
                any                                  = 1'b1;
                grant[(int'(last_lane) + k) % N]     = 1'b1;
                idx                                  = W'((int'(last_lane) + k) % N);
            end
        end
    end

endmodule

// File: rtl/parking_gate_arbiter.sv
// Shares the occupancy counter's event port between entry/exit lanes and
// drives per-lane barrier timers. Optional PARKING_UNI_PRIORITY_EN macro
// gives university cars precedence in arbitration.
module parking_gate_arbiter
    import parking_pkg::*;
#(
    parameter int NUM_ENTRY     = DEF_NUM_ENTRY,
    parameter int NUM_EXIT      = DEF_NUM_EXIT,
    parameter int OPEN_CYCLES   = DEF_OPEN_CYCLES,
    parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_ENTRY-1:0]          entry_req,
    input  logic [NUM_ENTRY-1:0]          entry_is_uni,
    input  logic [NUM_EXIT-1:0]           exit_req,
    input  logic [NUM_EXIT-1:0]           exit_is_uni,
    input  logic                          uni_is_vacated_space,
    input  logic                          is_vacated_space,
    output logic                          car_entered,
    output logic                          is_uni_car_entered,
    output logic                          car_exited,
    output logic                          is_uni_car_exited,
    output logic [NUM_ENTRY-1:0]          entry_grant,
    output logic [NUM_ENTRY-1:0]          entry_deny,
    output logic [NUM_EXIT-1:0]           exit_grant,
    output logic [NUM_ENTRY+NUM_EXIT-1:0] gate_open,
    output logic                          busy
);

    localparam int N  = NUM_ENTRY + NUM_EXIT;
    localparam int LW = lane_w(N);
    localparam int TW = $clog2(OPEN_CYCLES + 1);
    localparam int SW = lane_w(SETTLE_CYCLES + 1);

    state_t         state, next_state;
    logic [LW-1:0]  last_lane, win_lane, pick_idx;
    logic [N-1:0]   req_all, uni_all, eligible, pick_grant, lane_oh;
    logic           pick_any, win_uni, win_req, win_entry, flag_ok;
    logic           do_commit, do_deny;
    logic [SW-1:0]  settle_cnt;
    logic [TW-1:0]  timer [N];

    assign req_all   = {exit_req, entry_req};
    assign uni_all   = {exit_is_uni, entry_is_uni};
    assign eligible  = req_all & ~gate_open;
    assign lane_oh   = N'(1) << win_lane;
    assign win_req   = req_all[win_lane];
    assign win_entry = int'(win_lane) < NUM_ENTRY;
    assign flag_ok   = win_uni ? uni_is_vacated_space : is_vacated_space;

`ifdef PARKING_UNI_PRIORITY_EN
    logic [N-1:0]  grant_uni, grant_rest;
    logic [LW-1:0] idx_uni, idx_rest;
    logic          any_uni, any_rest;

    parking_rr_arbiter #(.N(N), .W(LW)) u_arb_uni (
        .req(eligible & uni_all), .last_lane(last_lane),
        .grant(grant_uni), .idx(idx_uni), .any(any_uni)
    );
    parking_rr_arbiter #(.N(N), .W(LW)) u_arb_rest (
        .req(eligible & ~uni_all), .last_lane(last_lane),
        .grant(grant_rest), .idx(idx_rest), .any(any_rest)
    );

    assign pick_grant = any_uni ? grant_uni : grant_rest;
    assign pick_idx   = any_uni ? idx_uni : idx_rest;
    assign pick_any   = any_uni | any_rest;
`else
    parking_rr_arbiter #(.N(N), .W(LW)) u_arb (
        .req(eligible), .last_lane(last_lane),
        .grant(pick_grant), .idx(pick_idx), .any(pick_any)
    );
`endif

    // The settle window runs from the cycle after the event up to the IDLE
    // capture cycle, so SETTLE itself occupies SETTLE_CYCLES-1 cycles.
    always_comb begin
        next_state = state;
        do_commit  = 1'b0;
        do_deny    = 1'b0;
        case (state)
            IDLE:   if (pick_any) next_state = EVAL;
            EVAL: begin
                if (!win_req) begin
                    next_state = IDLE;
                end else if (win_entry && !flag_ok) begin
                    do_deny    = 1'b1;
                    next_state = IDLE;
                end else begin
                    do_commit  = 1'b1;
                    next_state = COMMIT;
                end
            end
            COMMIT: next_state = (SETTLE_CYCLES > 1) ? SETTLE : IDLE;
            SETTLE: if (settle_cnt == '0) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            busy  <= 1'b0;
        end else begin
            state <= next_state;
            busy  <= (next_state != IDLE);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_lane          <= LW'(N - 1);
            win_lane           <= '0;
            win_uni            <= 1'b0;
            settle_cnt         <= '0;
            entry_grant        <= '0;
            entry_deny         <= '0;
            exit_grant         <= '0;
            car_entered        <= 1'b0;
            is_uni_car_entered <= 1'b0;
            car_exited         <= 1'b0;
            is_uni_car_exited  <= 1'b0;
            gate_open          <= '0;
            for (int i = 0; i < N; i++) timer[i] <= '0;
        end else begin
            entry_grant        <= '0;
            entry_deny         <= '0;
            exit_grant         <= '0;
            car_entered        <= 1'b0;
            is_uni_car_entered <= 1'b0;
            car_exited         <= 1'b0;
            is_uni_car_exited  <= 1'b0;

            if (state == IDLE && pick_any) begin
                win_lane <= pick_idx;
                win_uni  <= |(pick_grant & uni_all);
            end

            if (do_deny) begin
                entry_deny <= lane_oh[NUM_ENTRY-1:0];
                last_lane  <= win_lane;
            end

            if (do_commit) begin
                last_lane <= win_lane;
                if (win_entry) begin
                    entry_grant        <= lane_oh[NUM_ENTRY-1:0];
                    car_entered        <= 1'b1;
                    is_uni_car_entered <= win_uni;
                end else begin
                    exit_grant        <= lane_oh[N-1:NUM_ENTRY];
                    car_exited        <= 1'b1;
                    is_uni_car_exited <= win_uni;
                end
            end

            if (state == COMMIT)
                settle_cnt <= SW'((SETTLE_CYCLES > 1) ? SETTLE_CYCLES - 2 : 0);
            else if (state == SETTLE && settle_cnt != '0)
                settle_cnt <= settle_cnt - 1'b1;

            // Gate drops on the same edge its timer reaches zero.
            for (int i = 0; i < N; i++) begin
                if (do_commit && lane_oh[i]) begin
                    timer[i]     <= TW'(OPEN_CYCLES);
                    gate_open[i] <= 1'b1;
                end else if (timer[i] != '0) begin
                    timer[i] <= timer[i] - 1'b1;
                    if (timer[i] == TW'(1)) gate_open[i] <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_parking_gate_arbiter.sv
// Scoreboard bench: stimulus pushes expected event vectors, a negedge
// monitor pops and compares whenever the arbiter emits any pulse.
module tb_parking_gate_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] entry_req, entry_is_uni, exit_req, exit_is_uni;
    logic       uni_is_vacated_space, is_vacated_space;
    logic       car_entered, is_uni_car_entered, car_exited, is_uni_car_exited;
    logic [1:0] entry_grant, entry_deny, exit_grant;
    logic [3:0] gate_open;
    logic       busy;

    always #5 clk = ~clk;

    parking_gate_arbiter dut (
        .clk(clk), .reset(reset),
        .entry_req(entry_req), .entry_is_uni(entry_is_uni),
        .exit_req(exit_req), .exit_is_uni(exit_is_uni),
        .uni_is_vacated_space(uni_is_vacated_space), .is_vacated_space(is_vacated_space),
        .car_entered(car_entered), .is_uni_car_entered(is_uni_car_entered),
        .car_exited(car_exited), .is_uni_car_exited(is_uni_car_exited),
        .entry_grant(entry_grant), .entry_deny(entry_deny), .exit_grant(exit_grant),
        .gate_open(gate_open), .busy(busy)
    );

    // {entry_grant, entry_deny, exit_grant, ce, uce, cx, ucx}
    logic [9:0] obs;
    logic [3:0] lane_pulse;
    assign obs = {entry_grant, entry_deny, exit_grant,
                  car_entered, is_uni_car_entered, car_exited, is_uni_car_exited};
    assign lane_pulse = {exit_grant, entry_grant | entry_deny};

    int         vectors = 0;
    int         miscompares = 0;
    int         cyc = 0;
    logic [9:0] exp_q[$];
    int         grant_cyc[$];
    logic [9:0] mon_exp;

    function automatic logic [9:0] ev_in(input int lane, input bit uni);
        logic [9:0] v;
        v = '0; v[8 + lane] = 1'b1; v[3] = 1'b1; v[2] = uni;
        return v;
    endfunction

    function automatic logic [9:0] ev_deny(input int lane);
        logic [9:0] v;
        v = '0; v[6 + lane] = 1'b1;
        return v;
    endfunction

    function automatic logic [9:0] ev_out(input int lane, input bit uni);
        logic [9:0] v;
        v = '0; v[4 + lane - 2] = 1'b1; v[1] = 1'b1; v[0] = uni;
        return v;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!reset && obs != '0) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_event got %b required none", obs);
            end else begin
                mon_exp = exp_q.pop_front();
                if (obs !== mon_exp) begin
                    miscompares++;
                    $display("FAIL event got %b required %b", obs, mon_exp);
                end
            end
            if (obs[3] | obs[1]) grant_cyc.push_back(cyc);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s got %0h required %0h", name, act, req);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int lane, input logic val);
        if (lane < 2) entry_req[lane] = val;
        else exit_req[lane - 2] = val;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        entry_req = '0; exit_req = '0;
        tick(2);
        reset = 1'b0;
        tick(1);
    endtask

    task automatic wait_pulse(input int lane);
        bit seen;
        int k;
        seen = 0; k = 0;
        while (!seen && k < 60) begin
            @(negedge clk); k++;
            if (lane_pulse[lane]) seen = 1;
        end
        if (!seen) begin
            vectors++; miscompares++;
            $display("FAIL pulse_timeout lane %0d got none required pulse", lane);
        end
        @(posedge clk); #1;
    endtask

    task automatic wait_drain();
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < 80) begin
            @(negedge clk); k++;
        end
        if (exp_q.size() != 0) begin
            vectors++; miscompares++;
            $display("FAIL drain_timeout got %0d pending required 0", exp_q.size());
        end
        @(posedge clk); #1;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog got no finish required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        reset = 1'b1;
        entry_req = '0; exit_req = '0; entry_is_uni = '0; exit_is_uni = '0;
        uni_is_vacated_space = 1'b0; is_vacated_space = 1'b1;
        #1;
        chk("reset_gate", 32'(gate_open), 0);
        chk("reset_busy", 32'(busy), 0);
        chk("reset_pulses", 32'(obs), 0);
        tick(2);
        reset = 1'b0;
        tick(1);

        // Single entry grant, gate hold time, busy timing.
        exp_q.push_back(ev_in(0, 0));
        set_req(0, 1'b1);
        wait_pulse(0);
        set_req(0, 1'b0);
        chk("busy_settle", 32'(busy), 1);
        tick(1);
        chk("busy_fall", 32'(busy), 0);
        chk("gate_only0", 32'(gate_open), 32'h1);
        cnt = 2;
        for (int k = 0; k < 40 && gate_open[0]; k++) begin
            @(negedge clk);
            if (gate_open[0]) cnt++;
        end
        chk("gate0_hold", cnt, 16);

        // University car denied on a full university pool.
        entry_is_uni = 2'b10; uni_is_vacated_space = 1'b0; is_vacated_space = 1'b1;
        exp_q.push_back(ev_deny(1));
        set_req(1, 1'b1);
        wait_pulse(1);
        set_req(1, 1'b0);
        tick(4);
        chk("deny_no_gate", 32'(gate_open), 0);
        chk("deny_idle", 32'(busy), 0);

        // All four lanes together: lane order, 4-cycle spacing.
        do_reset();
        entry_is_uni = 2'b00; exit_is_uni = 2'b10;
        exp_q.push_back(ev_in(0, 0));
        exp_q.push_back(ev_in(1, 0));
        exp_q.push_back(ev_out(2, 0));
        exp_q.push_back(ev_out(3, 1));
        grant_cyc.delete();
        entry_req = 2'b11; exit_req = 2'b11;
        wait_pulse(3);
        entry_req = '0; exit_req = '0;
        chk("four_grants", grant_cyc.size(), 4);
        for (int i = 1; i < grant_cyc.size(); i++)
            chk("grant_spacing", grant_cyc[i] - grant_cyc[i-1], 4);

        // Lane 0 masked while its gate is open; lane 2 served meanwhile.
        do_reset();
        exit_is_uni = 2'b00;
        exp_q.push_back(ev_in(0, 0));
        set_req(0, 1'b1);
        wait_pulse(0);
        exp_q.push_back(ev_out(2, 0));
        exp_q.push_back(ev_in(0, 0));
        set_req(2, 1'b1);
        wait_pulse(2);
        set_req(2, 1'b0);
        chk("gate0_still_open", 32'(gate_open[0]), 1);
        wait_pulse(0);
        set_req(0, 1'b0);

        // Reset during COMMIT aborts silently; lane 0 wins afterwards.
        do_reset();
        entry_req = 2'b11;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        chk("abort_pulses", 32'(obs), 0);
        chk("abort_gate", 32'(gate_open), 0);
        chk("abort_busy", 32'(busy), 0);
        tick(2);
        reset = 1'b0;
        exp_q.push_back(ev_in(0, 0));
        exp_q.push_back(ev_in(1, 0));
        wait_pulse(0);
        set_req(0, 1'b0);
        wait_pulse(1);
        set_req(1, 1'b0);

        // Request withdrawn during EVAL: no pulses, back to IDLE.
        tick(2);
        set_req(2, 1'b1);
        @(posedge clk);
        #1;
        set_req(2, 1'b0);
        chk("eval_busy", 32'(busy), 1);
        tick(3);
        chk("cancel_idle", 32'(busy), 0);
        chk("cancel_no_gate", 32'(gate_open[2]), 0);

        // Lanes 0 (non-uni) and 3 (uni) together.
        do_reset();
        entry_is_uni = 2'b00; exit_is_uni = 2'b10;
`ifdef PARKING_UNI_PRIORITY_EN
        exp_q.push_back(ev_out(3, 1));
        exp_q.push_back(ev_in(0, 0));
`else
        exp_q.push_back(ev_in(0, 0));
        exp_q.push_back(ev_out(3, 1));
`endif
        set_req(0, 1'b1);
        set_req(3, 1'b1);
        wait_drain();
        entry_req = '0; exit_req = '0;

        tick(5);
        chk("queue_empty", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/parking_gate_arbiter.md
# parking_gate_arbiter

Sequencer that shares the single event port of the parking occupancy counter between multiple physical entry and exit lanes. It arbitrates lane requests round-robin and checks the counter's vacancy flags before admitting an entering car. It then issues exactly one single-cycle `car_entered`/`car_exited` event per admitted car and drives each lane's barrier for a fixed hold time. It sits between the lane sensors and the occupancy counter; the counter's vacancy flags feed back into this block.

## Interface
- `NUM_ENTRY`, 2: entry lanes; lane indices 0..NUM_ENTRY-1.
- `NUM_EXIT`, 2: exit lanes; lane indices NUM_ENTRY..NUM_ENTRY+NUM_EXIT-1.
- `OPEN_CYCLES`, 16: barrier hold time in clk cycles; must be ≥1.
- `SETTLE_CYCLES`, 2: cycles waited after an event for the counter flags to update; must be ≥1.
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-high.
- `entry_req`  in  NUM_ENTRY  car waiting at entry lane; level, held until grant or deny.
- `entry_is_uni`  in  NUM_ENTRY  car at that entry lane is a university car; valid while its req is high.
- `exit_req`  in  NUM_EXIT  car waiting at exit lane; level.
- `exit_is_uni`  in  NUM_EXIT  car at that exit lane is a university car.
- `uni_is_vacated_space`  in  1  counter flag: university space free.
- `is_vacated_space`  in  1  counter flag: non-university space free.
- `car_entered`, `is_uni_car_entered`, `car_exited`, `is_uni_car_exited`  out  1 each  single-cycle event to the counter.
- `entry_grant` / `entry_deny`  out  NUM_ENTRY  one-hot single-cycle pulses.
- `exit_grant`  out  NUM_EXIT  one-hot single-cycle pulse.
- `gate_open`  out  NUM_ENTRY+NUM_EXIT  level; the barrier for that lane is raised.
- `busy`  out  1  high whenever state ≠ IDLE.

## Operation
- FSM states: IDLE, EVAL, COMMIT, SETTLE.
- **IDLE**
  - Eligible lanes = lanes with req high and `gate_open` low.
  - If any lane is eligible, capture the round-robin winner, starting from `last_lane+1` with wrap. Capture its index and `is_uni`, then go to EVAL.
- **EVAL** (1 cycle)
  - If the winner's req has dropped: cancel, no pulses, go to IDLE, pointer unchanged.
  - Entry lane: the required flag is `uni_is_vacated_space` when `is_uni=1`, else `is_vacated_space`.
    - Flag low: pulse `entry_deny[lane]`, set `last_lane`=lane, go to IDLE.
    - Flag high: go to COMMIT.
  - Exit lane: always go to COMMIT.
- **COMMIT** (1 cycle)
  - Pulse the grant for the lane.
  - Entry: `car_entered=1`, `is_uni_car_entered=is_uni`.
  - Exit: `car_exited=1`, `is_uni_car_exited=is_uni`.
  - Set `gate_open[lane]`, load that lane's timer with OPEN_CYCLES, set `last_lane`, then go to SETTLE.
- **SETTLE**: wait SETTLE_CYCLES, then go to IDLE. No arbitration happens in this state.
- Event outputs are never high simultaneously. At most one event per transaction.
- Per-lane timers
  - Each lane has its own down-counter of width `$clog2(OPEN_CYCLES+1)`.
  - `gate_open` clears on the edge where the timer reaches 0.
  - Timers run independently of the FSM, so several gates may be open at once.
  - A lane whose gate is open is masked from arbitration.
- Requesters must drop req after grant or deny. A req still high after `gate_open` falls is treated as a new car.
- Reset, asynchronous, at any time including mid-transaction:
  - state=IDLE, `last_lane`=NUM_ENTRY+NUM_EXIT-1 (so lane 0 wins first);
  - all timers 0;
  - every output 0: pulses, `gate_open`, `busy`.
  - No event is emitted for an aborted transaction.

## Timing
- All outputs are registered.
- Request seen at edge N (IDLE→EVAL):
  - deny pulse or COMMIT pulses are high for the single cycle after edge N+1;
  - `gate_open` rises at edge N+1 and stays high exactly OPEN_CYCLES cycles.
- Earliest next capture: edge N+2+SETTLE_CYCLES. With defaults, one transaction per 4 cycles; a deny costs 2 cycles.
- Flags are sampled only in EVAL, at least SETTLE_CYCLES after the previous event.

## Configuration
- `PARKING_UNI_PRIORITY_EN` defined:
  - In IDLE, eligible lanes whose `is_uni` bit is high (entry or exit) win over all other lanes.
  - Round-robin applies within the university set first, then within the rest.
- Undefined: pure round-robin; `is_uni` does not affect the choice of winner.

## Structure
- Shared package `parking_pkg` holds:
  - the FSM state enum;
  - default lane counts, OPEN_CYCLES and SETTLE_CYCLES;
  - a lane-index width function.
- Sub-module `parking_rr_arbiter`: a rotating-priority picker.
  - Inputs: request vector and `last_lane`.
  - Outputs: one-hot winner, index, `any`.
  - It is instantiated once; under the macro it is instantiated twice (university set and rest).

## Test plan
- Reset, then `entry_req[0]=1`, `is_uni=0`, `is_vacated_space=1`: `car_entered` and `entry_grant[0]` pulse once; `gate_open[0]` is high for 16 cycles; `busy` falls after 4 cycles.
- `entry_req[1]=1`, `is_uni=1`, `uni_is_vacated_space=0`: `entry_deny[1]` pulses; no event, no gate.
- All four reqs held high together: grants go in lane order 0,1,2,3, one every 4 cycles. Exits pulse `car_exited` with `is_uni_car_exited` matching `exit_is_uni`.
- Lane 0 re-requests while `gate_open[0]` is high: it is not granted until the gate closes; lane 2 is served meanwhile.
- Assert `reset` during COMMIT: all outputs are 0 immediately, no later event. After release, lane 0 wins first.
- Drop req during EVAL: no pulses, FSM returns to IDLE. With the macro defined and lanes 0 (non-uni) and 3 (uni) requesting: lane 3 is granted first.
